// File: rtl/caravel_mini_pkg.sv
// Shared definitions for the project select controller: FSM states,
// status register bit positions and the default register address.
package caravel_mini_pkg;

    // Controller phases: strap sampling, project reset window, normal running.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int          BUSY_BIT            = 16;
    localparam int          ERR_BIT             = 17;
    localparam logic [31:0] DEFAULT_CFG_ADDRESS = 32'h300F_FFFC;

    // BOOT lasts this many cycles: two to fill the strap synchronizer, one to load.
    localparam int          BOOT_CYCLES         = 3;

endpackage

// File: rtl/project_select_ctrl_if.sv
// Wishbone classic slave bundle between the management SoC and the select controller.
interface project_select_ctrl_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for quasi-static asynchronous inputs (IO straps).
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Shift the pad value through two flops so metastability settles before use.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/project_select_ctrl.sv
// Project select controller: boots the select from strap pins, exposes it as a
// Wishbone register, and sequences every switch as reset-hold / change / release / IRQ.
module project_select_ctrl
    import caravel_mini_pkg::*;
#(
    parameter logic [31:0] CFG_ADDRESS   = DEFAULT_CFG_ADDRESS,
    parameter int          USER_PROJECTS = 4,
    parameter int          CFG_BITS      = $clog2(USER_PROJECTS),
    parameter int          RST_CYCLES    = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    project_select_ctrl_if.slave     wb,
    input  logic [CFG_BITS-1:0]      strap_i,
    output logic [CFG_BITS-1:0]      cfg_sel_o,
    output logic [USER_PROJECTS-1:0] proj_rst_no,
    output logic                     cfg_irq_o
);

    localparam int                  CNT_W     = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [1:0]          BOOT_LAST = 2'(BOOT_CYCLES - 1);
    localparam logic [CFG_BITS:0]   PROJ_EXT  = (CFG_BITS + 1)'(USER_PROJECTS);
    localparam logic [CFG_BITS-1:0] LAST_SEL  = CFG_BITS'(USER_PROJECTS - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_boot_cnt;
    logic [CFG_BITS-1:0] r_sel;
    logic                r_err;
    logic                r_irq;
    logic                r_switched;
    logic                r_ack;
    logic [31:0]         r_dat;
    logic                r_served;

    logic [CFG_BITS-1:0] w_strap_sync;
    logic [CFG_BITS-1:0] w_strap_clamped;
    logic [CFG_BITS-1:0] w_wr_val;
    logic                w_in_range;
    logic                w_boot_done;
    logic                w_hold_done;
    logic                w_busy;
    logic                w_hit;
    logic                w_req;
    logic                w_wr;
    logic                w_accept;
    logic                w_reject;
    logic                w_err_clr;
    logic [31:0]         w_rd_val;
    logic                w_unused;

    sync_2ff #(
        .WIDTH (CFG_BITS)
    ) u_strap_sync (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_ni),
        .i_d     (strap_i),
        .o_q     (w_strap_sync)
    );

    // Out-of-range strap values boot the highest-numbered project.
    assign w_strap_clamped = ({1'b0, w_strap_sync} < PROJ_EXT) ? w_strap_sync : LAST_SEL;

    // One acknowledge per strobe assertion; a held strobe is not answered twice.
    assign w_hit     = wb.wbs_cyc_i && wb.wbs_stb_i && (wb.wbs_adr_i == CFG_ADDRESS);
    assign w_req     = w_hit && !r_served;
    assign w_wr      = w_req && wb.wbs_we_i;
    assign w_wr_val  = wb.wbs_dat_i[CFG_BITS-1:0];
    assign w_in_range = ({1'b0, w_wr_val} < PROJ_EXT);

    // Lane 0 carries the select; writes with it disabled leave select and error alone.
    assign w_accept  = w_wr && wb.wbs_sel_i[0] && (r_state == RUN) && w_in_range
                       && (w_wr_val != r_sel);
    assign w_reject  = w_wr && wb.wbs_sel_i[0] && ((r_state != RUN) || !w_in_range);
    assign w_err_clr = w_wr && wb.wbs_sel_i[2] && wb.wbs_dat_i[ERR_BIT];

    assign w_boot_done = (r_state == BOOT) && (r_boot_cnt == BOOT_LAST);
    assign w_hold_done = (r_state == HOLD) && (r_cnt == CNT_LAST);

    // Only part of the data word and byte enables are meaningful to this register.
    assign w_unused = ^{wb.wbs_dat_i, wb.wbs_sel_i};

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            BOOT:    if (w_boot_done) w_next_state = HOLD;
            HOLD:    if (w_hold_done) w_next_state = RUN;
            RUN:     if (w_accept)    w_next_state = HOLD;
            default: w_next_state = BOOT;
        endcase
    end

    // FSM outputs: projects are held in reset everywhere except RUN.
    always_comb begin
        w_busy      = 1'b1;
        proj_rst_no = '0;
        if (r_state == RUN) begin
            w_busy      = 1'b0;
            proj_rst_no = '1;
        end
    end

    // Boot and reset-window counters; the window counter restarts on every HOLD entry.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_boot_cnt <= '0;
            r_cnt      <= '0;
        end else begin
            r_boot_cnt <= (r_state == BOOT && !w_boot_done) ? r_boot_cnt + 2'd1 : 2'd0;
            r_cnt      <= (r_state == HOLD && !w_hold_done) ? r_cnt + CNT_W'(1) : '0;
        end
    end

    // Select, sticky error and switch-complete interrupt.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_sel      <= '0;
            r_err      <= 1'b0;
            r_irq      <= 1'b0;
            r_switched <= 1'b0;
        end else begin
            if (w_boot_done) begin
                r_sel <= w_strap_clamped;
            end else if (w_accept) begin
                r_sel <= w_wr_val;
            end
            // A rejection in the same write wins over a clear so it is never lost.
            if (w_reject) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end
            // The boot-time HOLD is not a switch, so it raises no interrupt.
            if (w_accept) begin
                r_switched <= 1'b1;
            end
            r_irq <= w_hold_done && r_switched;
        end
    end

    // Status word as seen by a read.
    always_comb begin
        w_rd_val                 = '0;
        w_rd_val[CFG_BITS-1:0]   = r_sel;
        w_rd_val[BUSY_BIT]       = w_busy;
        w_rd_val[ERR_BIT]        = r_err;
    end

    // Registered Wishbone response; read data is zero outside the ack cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_served <= 1'b0;
        end else begin
            r_ack    <= w_req;
            r_dat    <= w_req ? w_rd_val : 32'd0;
            r_served <= w_req || (r_served && wb.wbs_cyc_i && wb.wbs_stb_i);
        end
    end

    assign wb.wbs_ack_o = r_ack;
    assign wb.wbs_dat_o = r_dat;
    assign cfg_sel_o    = r_sel;
    assign cfg_irq_o    = r_irq;

endmodule

// File: tb/tb_project_select_ctrl.sv
// Self-checking bench for project_select_ctrl: directed scenarios plus a
// randomized bus phase compared against a behavioural model of the register.
module tb_project_select_ctrl;
    import caravel_mini_pkg::*;

    localparam int          RST_CYCLES = 16;
    localparam logic [31:0] CFG_ADDR   = 32'h300F_FFFC;
    localparam logic [31:0] OTHER_ADDR = 32'h300F_FFF8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    project_select_ctrl_if bus4 ();
    project_select_ctrl_if bus3 ();

    logic [1:0] strap4, strap3, sel4, sel3;
    logic [3:0] rst4;
    logic [2:0] rst3;
    logic       irq4, irq3;

    project_select_ctrl #(
        .CFG_ADDRESS (CFG_ADDR), .USER_PROJECTS (4), .RST_CYCLES (RST_CYCLES)
    ) dut4 (
        .wb_clk_i (clk), .wb_rst_ni (rst_n), .wb (bus4), .strap_i (strap4),
        .cfg_sel_o (sel4), .proj_rst_no (rst4), .cfg_irq_o (irq4)
    );

    project_select_ctrl #(
        .CFG_ADDRESS (CFG_ADDR), .USER_PROJECTS (3), .RST_CYCLES (RST_CYCLES)
    ) dut3 (
        .wb_clk_i (clk), .wb_rst_ni (rst_n), .wb (bus3), .strap_i (strap3),
        .cfg_sel_o (sel3), .proj_rst_no (rst3), .cfg_irq_o (irq3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model of the 4-project instance: phases as remaining-cycle counts.
    int          m_boot_left, m_hold_left;
    bit          m_switched, m_served, m_err, m_ack, m_irq;
    logic [1:0]  m_sel, m_strap_seen;
    logic [31:0] m_dat;

    function automatic void model_reset();
        m_boot_left  = 3;
        m_hold_left  = 0;
        m_switched   = 0;
        m_served     = 0;
        m_err        = 0;
        m_ack        = 0;
        m_irq        = 0;
        m_sel        = 2'd0;
        m_strap_seen = 2'd0;
        m_dat        = 32'd0;
    endfunction

    function automatic logic [3:0] m_rst_exp();
        return (m_boot_left == 0 && m_hold_left == 0) ? 4'hF : 4'h0;
    endfunction

    // Advance the model by one clock edge using the inputs present before the edge.
    function automatic void model_step();
        bit          run, hit, req, wr, lane0;
        logic [31:0] rd;
        logic [1:0]  v;
        if (!rst_n) begin
            model_reset();
            return;
        end
        run   = (m_boot_left == 0 && m_hold_left == 0);
        hit   = bus4.wbs_cyc_i && bus4.wbs_stb_i && (bus4.wbs_adr_i == CFG_ADDR);
        req   = hit && !m_served;
        wr    = req && bus4.wbs_we_i;
        lane0 = bus4.wbs_sel_i[0];
        v     = bus4.wbs_dat_i[1:0];
        rd    = 32'(m_sel) + (run ? 32'd0 : 32'h0001_0000) + (m_err ? 32'h0002_0000 : 32'd0);
        m_ack    = req;
        m_dat    = req ? rd : 32'd0;
        m_served = req || (m_served && bus4.wbs_cyc_i && bus4.wbs_stb_i);
        m_irq    = 0;
        if (wr && lane0 && !run) m_err = 1;
        else if (wr && bus4.wbs_sel_i[2] && bus4.wbs_dat_i[17]) m_err = 0;
        if (m_boot_left > 0) begin
            if (m_boot_left == 3) m_strap_seen = strap4;
            m_boot_left--;
            if (m_boot_left == 0) begin
                m_sel       = m_strap_seen;
                m_hold_left = RST_CYCLES;
            end
        end else if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0 && m_switched) m_irq = 1;
        end else if (wr && lane0 && v != m_sel) begin
            m_sel       = v;
            m_hold_left = RST_CYCLES;
            m_switched  = 1;
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus4_drive(input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input logic we);
        bus4.wbs_cyc_i = 1'b1;
        bus4.wbs_stb_i = 1'b1;
        bus4.wbs_adr_i = adr;
        bus4.wbs_dat_i = dat;
        bus4.wbs_sel_i = sel;
        bus4.wbs_we_i  = we;
    endtask

    task automatic bus4_idle();
        bus4.wbs_cyc_i = 1'b0;
        bus4.wbs_stb_i = 1'b0;
        bus4.wbs_adr_i = 32'd0;
        bus4.wbs_dat_i = 32'd0;
        bus4.wbs_sel_i = 4'd0;
        bus4.wbs_we_i  = 1'b0;
    endtask

    task automatic bus3_drive(input logic [31:0] dat, input logic we);
        bus3.wbs_cyc_i = 1'b1;
        bus3.wbs_stb_i = 1'b1;
        bus3.wbs_adr_i = CFG_ADDR;
        bus3.wbs_dat_i = dat;
        bus3.wbs_sel_i = 4'hF;
        bus3.wbs_we_i  = we;
    endtask

    task automatic bus3_idle();
        bus3.wbs_cyc_i = 1'b0;
        bus3.wbs_stb_i = 1'b0;
        bus3.wbs_adr_i = 32'd0;
        bus3.wbs_dat_i = 32'd0;
        bus3.wbs_sel_i = 4'd0;
        bus3.wbs_we_i  = 1'b0;
    endtask

    // Tick until the 4-project instance releases its projects, bounded.
    task automatic wait_run(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (rst4 == 4'hF) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (rst4 == 4'hF) ok = 1;
    endtask

    task automatic test_reset();
        strap4 = 2'd3;
        strap3 = 2'd3;
        bus4_idle();
        bus3_idle();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        n_cmp++;
        if ({bus4.wbs_ack_o, bus4.wbs_dat_o, sel4, rst4, irq4} !== 40'd0) begin
            n_bad++;
            $display("FAIL reset_dut4: got ack=%b dat=%h sel=%h rst=%b irq=%b want all 0",
                     bus4.wbs_ack_o, bus4.wbs_dat_o, sel4, rst4, irq4);
        end
        n_cmp++;
        if ({bus3.wbs_ack_o, bus3.wbs_dat_o, sel3, rst3, irq3} !== 39'd0) begin
            n_bad++;
            $display("FAIL reset_dut3: got ack=%b dat=%h sel=%h rst=%b irq=%b want all 0",
                     bus3.wbs_ack_o, bus3.wbs_dat_o, sel3, rst3, irq3);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_boot();
        int irq_seen = 0;
        for (int c = 1; c <= 19; c++) begin
            tick();
            if (irq4) irq_seen++;
            n_cmp++;
            if ({bus4.wbs_ack_o, bus4.wbs_dat_o, sel4, rst4, irq4} !==
                {m_ack, m_dat, m_sel, m_rst_exp(), m_irq}) begin
                n_bad++;
                $display("FAIL boot_model c%0d: got sel=%h rst=%b irq=%b want sel=%h rst=%b irq=%b",
                         c, sel4, rst4, irq4, m_sel, m_rst_exp(), m_irq);
            end
            if (c == 2) begin
                n_cmp++;
                if (sel4 !== 2'd0) begin
                    n_bad++;
                    $display("FAIL boot_sel_c2: got %h want 0", sel4);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if (sel4 !== 2'd3 || rst4 !== 4'h0) begin
                    n_bad++;
                    $display("FAIL boot_sel_c3: got sel=%h rst=%b want sel=3 rst=0000", sel4, rst4);
                end
            end
            if (c == 18) begin
                n_cmp++;
                if (rst4 !== 4'h0) begin
                    n_bad++;
                    $display("FAIL boot_rst_c18: got %b want 0000", rst4);
                end
            end
            if (c == 19) begin
                n_cmp++;
                if (rst4 !== 4'hF) begin
                    n_bad++;
                    $display("FAIL boot_rst_c19: got %b want 1111", rst4);
                end
            end
        end
        n_cmp++;
        if (irq_seen != 0) begin
            n_bad++;
            $display("FAIL boot_irq: got %0d pulses want 0", irq_seen);
        end
    endtask

    task automatic test_switch();
        int low_cnt = 1;
        bit irq_first;
        bus4_drive(CFG_ADDR, 32'h1, 4'hF, 1'b1);
        tick();
        n_cmp++;
        if (bus4.wbs_ack_o !== 1'b1 || bus4.wbs_dat_o !== 32'h3 || sel4 !== 2'd1 || rst4 !== 4'h0) begin
            n_bad++;
            $display("FAIL switch_ack: got ack=%b dat=%h sel=%h rst=%b want ack=1 dat=3 sel=1 rst=0000",
                     bus4.wbs_ack_o, bus4.wbs_dat_o, sel4, rst4);
        end
        bus4_idle();
        irq_first = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rst4 == 4'h0) low_cnt++;
            else begin
                irq_first = irq4;
                break;
            end
        end
        n_cmp++;
        if (low_cnt != RST_CYCLES) begin
            n_bad++;
            $display("FAIL switch_low_cycles: got %0d want %0d", low_cnt, RST_CYCLES);
        end
        n_cmp++;
        if (irq_first !== 1'b1) begin
            n_bad++;
            $display("FAIL switch_irq_first_run: got %b want 1", irq_first);
        end
        tick();
        n_cmp++;
        if (irq4 !== 1'b0) begin
            n_bad++;
            $display("FAIL switch_irq_width: got %b want 0", irq4);
        end
        bus4_drive(CFG_ADDR, 32'h0, 4'hF, 1'b0);
        tick();
        n_cmp++;
        if (bus4.wbs_ack_o !== 1'b1 || bus4.wbs_dat_o !== 32'h1) begin
            n_bad++;
            $display("FAIL switch_readback: got ack=%b dat=%h want ack=1 dat=00000001",
                     bus4.wbs_ack_o, bus4.wbs_dat_o);
        end
        bus4_idle();
        tick();
    endtask

    task automatic test_reject_busy();
        bit ok;
        bus4_drive(CFG_ADDR, 32'h3, 4'hF, 1'b1);
        tick();
        bus4_idle();
        tick();
        bus4_drive(CFG_ADDR, 32'h2, 4'hF, 1'b1);
        tick();
        n_cmp++;
        if (bus4.wbs_ack_o !== 1'b1 || bus4.wbs_dat_o !== 32'h0001_0003 || sel4 !== 2'd3) begin
            n_bad++;
            $display("FAIL busy_write: got ack=%b dat=%h sel=%h want ack=1 dat=00010003 sel=3",
                     bus4.wbs_ack_o, bus4.wbs_dat_o, sel4);
        end
        bus4_idle();
        wait_run(ok);
        n_cmp++;
        if (!ok || sel4 !== 2'd3) begin
            n_bad++;
            $display("FAIL busy_run_reached: got ok=%b sel=%h want ok=1 sel=3", ok, sel4);
        end
        bus4_drive(CFG_ADDR, 32'h1, 4'hF, 1'b1);
        tick();
        bus4_idle();
        wait_run(ok);
        bus4_drive(CFG_ADDR, 32'h0, 4'hF, 1'b0);
        tick();
        n_cmp++;
        if (bus4.wbs_dat_o !== 32'h0002_0001) begin
            n_bad++;
            $display("FAIL busy_err_read: got %h want 00020001", bus4.wbs_dat_o);
        end
        bus4_idle();
        tick();
        bus4_drive(CFG_ADDR, 32'h0002_0001, 4'hF, 1'b1);
        tick();
        bus4_idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (rst4 !== 4'hF || irq4 !== 1'b0) begin
                n_bad++;
                $display("FAIL noop_write: got rst=%b irq=%b want rst=1111 irq=0", rst4, irq4);
            end
        end
        bus4_drive(CFG_ADDR, 32'h0, 4'hF, 1'b0);
        tick();
        n_cmp++;
        if (bus4.wbs_dat_o !== 32'h1) begin
            n_bad++;
            $display("FAIL err_cleared_read: got %h want 00000001", bus4.wbs_dat_o);
        end
        bus4_idle();
        tick();
    endtask

    task automatic test_decode();
        int acks = 0;
        bus4_drive(OTHER_ADDR, 32'h0, 4'hF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus4.wbs_ack_o) acks++;
        end
        n_cmp++;
        if (acks != 0) begin
            n_bad++;
            $display("FAIL decode_other_addr: got %0d acks want 0", acks);
        end
        acks = 0;
        bus4_drive(CFG_ADDR, 32'h0, 4'hF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus4.wbs_ack_o) acks++;
        end
        bus4_idle();
        tick();
        if (bus4.wbs_ack_o) acks++;
        n_cmp++;
        if (acks != 1) begin
            n_bad++;
            $display("FAIL decode_held_stb: got %0d acks want 1", acks);
        end
        bus4_drive(CFG_ADDR, 32'h2, 4'b1110, 1'b1);
        tick();
        n_cmp++;
        if (bus4.wbs_ack_o !== 1'b1) begin
            n_bad++;
            $display("FAIL lane0_off_ack: got %b want 1", bus4.wbs_ack_o);
        end
        bus4_idle();
        tick();
        n_cmp++;
        if (sel4 !== 2'd1 || rst4 !== 4'hF) begin
            n_bad++;
            $display("FAIL lane0_off_sel: got sel=%h rst=%b want sel=1 rst=1111", sel4, rst4);
        end
        bus4_drive(CFG_ADDR, 32'h0, 4'hF, 1'b0);
        tick();
        n_cmp++;
        if (bus4.wbs_dat_o !== 32'h1) begin
            n_bad++;
            $display("FAIL lane0_off_read: got %h want 00000001", bus4.wbs_dat_o);
        end
        bus4_idle();
        tick();
    endtask

    task automatic test_out_of_range();
        n_cmp++;
        if (sel3 !== 2'd2 || rst3 !== 3'b111) begin
            n_bad++;
            $display("FAIL oor_strap_clamp: got sel=%h rst=%b want sel=2 rst=111", sel3, rst3);
        end
        bus3_drive(32'h3, 1'b1);
        tick();
        n_cmp++;
        if (bus3.wbs_ack_o !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_ack: got %b want 1", bus3.wbs_ack_o);
        end
        bus3_idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (sel3 !== 2'd2 || rst3 !== 3'b111 || irq3 !== 1'b0) begin
                n_bad++;
                $display("FAIL oor_no_switch: got sel=%h rst=%b irq=%b want sel=2 rst=111 irq=0",
                         sel3, rst3, irq3);
            end
        end
        bus3_drive(32'h0, 1'b0);
        tick();
        n_cmp++;
        if (bus3.wbs_dat_o !== 32'h0002_0002) begin
            n_bad++;
            $display("FAIL oor_err_read: got %h want 00020002", bus3.wbs_dat_o);
        end
        bus3_idle();
        tick();
        bus3_drive(32'h1, 1'b1);
        tick();
        n_cmp++;
        if (sel3 !== 2'd1 || rst3 !== 3'b000) begin
            n_bad++;
            $display("FAIL oor_valid_switch: got sel=%h rst=%b want sel=1 rst=000", sel3, rst3);
        end
        bus3_idle();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] d;
            d     = $urandom;
            d[17] = ($urandom_range(0, 7) == 0);
            bus4.wbs_cyc_i = ($urandom_range(0, 3) != 0);
            bus4.wbs_stb_i = bus4.wbs_cyc_i && ($urandom_range(0, 7) != 0);
            bus4.wbs_adr_i = ($urandom_range(0, 7) == 0) ? OTHER_ADDR : CFG_ADDR;
            bus4.wbs_we_i  = $urandom_range(0, 1) != 0;
            bus4.wbs_sel_i = 4'($urandom_range(0, 15)) | (($urandom_range(0, 3) != 0) ? 4'h1 : 4'h0);
            bus4.wbs_dat_i = d;
            tick();
            n_cmp++;
            if ({bus4.wbs_ack_o, bus4.wbs_dat_o, sel4, rst4, irq4} !==
                {m_ack, m_dat, m_sel, m_rst_exp(), m_irq}) begin
                n_bad++;
                $display("FAIL random_c%0d: got ack=%b dat=%h sel=%h rst=%b irq=%b want ack=%b dat=%h sel=%h rst=%b irq=%b",
                         i, bus4.wbs_ack_o, bus4.wbs_dat_o, sel4, rst4, irq4,
                         m_ack, m_dat, m_sel, m_rst_exp(), m_irq);
            end
        end
        bus4_idle();
        tick();
    endtask

    task automatic test_mid_reset();
        bit ok;
        int irq_seen = 0;
        wait_run(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL midrst_run_reached: got rst=%b want 1111", rst4);
        end
        bus4_drive(CFG_ADDR, 32'(m_sel + 2'd1), 4'hF, 1'b1);
        tick();
        bus4_idle();
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (rst4 !== 4'h0) begin
            n_bad++;
            $display("FAIL midrst_in_hold: got rst=%b want 0000", rst4);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({bus4.wbs_ack_o, bus4.wbs_dat_o, sel4, rst4, irq4} !== 40'd0 ||
            {bus3.wbs_ack_o, bus3.wbs_dat_o, sel3, rst3, irq3} !== 39'd0) begin
            n_bad++;
            $display("FAIL midrst_immediate: got sel4=%h rst4=%b sel3=%h rst3=%b want all 0",
                     sel4, rst4, sel3, rst3);
        end
        strap4 = 2'd1;
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            tick();
            if (irq4) irq_seen++;
            n_cmp++;
            if ({bus4.wbs_ack_o, bus4.wbs_dat_o, sel4, rst4, irq4} !==
                {m_ack, m_dat, m_sel, m_rst_exp(), m_irq}) begin
                n_bad++;
                $display("FAIL midrst_reboot c%0d: got sel=%h rst=%b want sel=%h rst=%b",
                         c, sel4, rst4, m_sel, m_rst_exp());
            end
            if (c == 3) begin
                n_cmp++;
                if (sel4 !== 2'd1) begin
                    n_bad++;
                    $display("FAIL midrst_strap_resample: got %h want 1", sel4);
                end
            end
        end
        n_cmp++;
        if (rst4 !== 4'hF || irq_seen != 0) begin
            n_bad++;
            $display("FAIL midrst_release: got rst=%b irq_pulses=%0d want rst=1111 irq_pulses=0",
                     rst4, irq_seen);
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_switch();
        test_reject_busy();
        test_decode();
        test_out_of_range();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
